// File: rtl/mem_block_mover.sv
// Block-transfer initiator for the byte-wide data memory port.
// COPY moves src..src+len-1 to dst..dst+len-1; FILL writes a constant over the destination run.
module mem_block_mover #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [DW-1:0] checksum,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  // state | meaning
  // IDLE  | waiting for start, memory port quiet
  // READ  | COPY: presenting src+idx, capturing mem_rd
  // WRITE | presenting dst+idx with write data, mem_we high
  // FIN   | one-cycle done pulse, back to IDLE
  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  state_t        state;
  logic          mode_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [DW-1:0] fill_q;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic          we_q;

  assign idx_nxt = idx + 1'b1;

  // Abort must kill the write of the cycle it arrives in, hence the only
  // combinational input-to-output path.
  assign mem_we = we_q & ~abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      checksum <= '0;
      mem_a    <= '0;
      mem_wd   <= '0;
      we_q     <= 1'b0;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            src_q    <= src;
            dst_q    <= dst;
            len_q    <= len;
            fill_q   <= fill_val;
            idx      <= '0;
            checksum <= '0;
            aborted  <= 1'b0;
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode) begin
              state  <= WRITE;
              busy   <= 1'b1;
              mem_a  <= dst;
              mem_wd <= fill_val;
              we_q   <= 1'b1;
            end else begin
              state <= READ;
              busy  <= 1'b1;
              mem_a <= src;
            end
          end
        end

        READ: begin
          if (abort) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            mem_a   <= '0;
          end else begin
            // mem_wd doubles as the read-data latch for the following WRITE
            state  <= WRITE;
            mem_a  <= dst_q + idx;
            mem_wd <= mem_rd;
            we_q   <= 1'b1;
          end
        end

        WRITE: begin
          if (abort) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            we_q    <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
          end else begin
            checksum <= checksum + mem_wd;
            idx      <= idx_nxt;
            if (idx_nxt == len_q) begin
              state  <= FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              we_q   <= 1'b0;
              mem_a  <= '0;
              mem_wd <= '0;
            end else if (mode_q) begin
              mem_a  <= dst_q + idx_nxt;
              mem_wd <= fill_q;
            end else begin
              state  <= READ;
              we_q   <= 1'b0;
              mem_a  <= src_q + idx_nxt;
              mem_wd <= '0;
            end
          end
        end

        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Block-transfer initiator for the 8-bit data memory port: performs COPY (src→dst) or FILL (constant→dst) over a run of bytes.
- Drives address, write data and write enable; consumes the memory's combinational read data.
- Sits between the control/CPU side (start/busy/done handshake) and the data memory, so bulk init and moves need no per-byte software writes.

Parameters:
- AW, 8, address width; address arithmetic wraps mod 2^AW.
- DW, 8, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = COPY, 1 = FILL; captured on accepted start.
- src  input  AW  COPY source base address; captured on start.
- dst  input  AW  destination base address; captured on start.
- len  input  AW  byte count, 0..2^AW-1; captured on start.
- fill_val  input  DW  FILL constant; captured on start.
- abort  input  1  synchronous cancel of the running transfer.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse at completion or abort.
- aborted  output  1  set with done if the transfer was aborted; held until next accepted start.
- checksum  output  DW  sum mod 2^DW of all bytes written by the current/last transfer.
- mem_a  output  AW  memory address.
- mem_wd  output  DW  memory write data.
- mem_we  output  1  memory write enable.
- mem_rd  input  DW  memory read data, combinational from mem_a.

Behaviour:
- Reset (rst low, async): state=IDLE; busy=0, done=0, aborted=0, checksum=0, mem_a=0, mem_wd=0, mem_we=0; internal idx, data latch and captured operands cleared.
- States: IDLE, READ, WRITE, FIN.
- IDLE: mem_we=0. On start=1, capture mode/src/dst/len/fill_val; clear idx, checksum, aborted.
  - len=0 → FIN.
  - COPY → READ.
  - FILL → WRITE.
- READ (COPY only): mem_a=src+idx, mem_we=0; latch mem_rd into data register at clock edge → WRITE.
- WRITE: mem_a=dst+idx, mem_wd=(COPY ? latched data : fill_val), mem_we=1.
  - At the edge, checksum += mem_wd and idx += 1.
  - If idx+1 == len → FIN; else COPY → READ, FILL → WRITE.
- FIN: done=1 for exactly this cycle, busy=0, mem_we=0 → IDLE.
- busy=1 in READ and WRITE; 0 in IDLE and FIN.
- Throughput: COPY takes 2 cycles/byte, FILL 1 cycle/byte. Start-to-done latency is 2·len+1 cycles (COPY), len+1 (FILL), 1 (len=0).
- Addresses: src+idx and dst+idx wrap mod 2^AW, e.g. dst=0xFE, len=4 writes 0xFE, 0xFF, 0x00, 0x01.
- Order: strictly ascending idx. Overlapping COPY with dst>src propagates already-written bytes; this is defined behaviour, not an error.
- Start while busy or in FIN: ignored, no capture.
- Abort in READ or WRITE: the current-cycle write is suppressed (mem_we forced 0) → FIN, aborted=1. checksum holds only the completed writes. Abort in IDLE or FIN: no effect.
- Abort and start in the same IDLE cycle: start wins, abort is ignored.
- All outputs are registered or decoded from state only. No combinational path from start/abort to mem_we except the abort suppression.
- Reset mid-transfer: immediate return to IDLE, outputs at reset values. The memory is untouched beyond writes already clocked.

Test Plan:
- FILL mode=1, dst=0x10, len=4, fill_val=0xA5 → mem[0x10..0x13]=0xA5; done 5 cycles after start; checksum=0x94; mem_we high 4 consecutive cycles.
- COPY mem[0x00..0x02]={0x01,0x02,0x03}, src=0x00, dst=0x80, len=3 → mem[0x80..0x82]={0x01,0x02,0x03}; done 7 cycles after start; checksum=0x06; mem_we alternates 0/1.
- Wrap: FILL dst=0xFE, len=4, fill_val=0x11 → writes at 0xFE, 0xFF, 0x00, 0x01 only; mem[0x02] unchanged.
- len=0 start → done pulse next cycle; no mem_we; busy never high; checksum=0.
- FILL len=10, abort asserted in the 3rd WRITE cycle → exactly 2 bytes written; done+aborted next cycle; a start pulsed during busy is ignored.
- Reset low mid-COPY → outputs to reset values asynchronously; after release, a new FILL start completes normally.
